// File: rtl/bitonic_sort_seq.sv
// Folded bitonic sorter: one compare-exchange stage of PN/2 comparators per clock on a register array.
// Latency: accept edge E0, stages on E1..ES with S = LP*(LP+1)/2, out_valid high after ES; S+2 cycles per vector.
// Backpressure: in_ready only in IDLE; d_out/out_valid held in DONE until out_ready.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   clr              synchronous abort back to IDLE; vector discarded, d_out untouched
//   in_valid/in_ready/d_in     vector load handshake, element i = d_in[i]
//   out_valid/out_ready/d_out  sorted vector handshake, d_out registered
//   busy             high while in SORT
//   swap_cnt         (only with BSORT_SWAP_CNT_EN) pairs swapped while sorting the current vector
//
// Optional feature macro: BSORT_SWAP_CNT_EN
module bitonic_sort_seq #(
  parameter int LP  = 3,  // log2 of element count, 1..6
  parameter int dw  = 8,  // element width, unsigned
  parameter int dir = 0   // 0 ascending, 1 descending
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2**LP-1:0][dw-1:0]    d_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2**LP-1:0][dw-1:0]    d_out,
  output logic                        busy
`ifdef BSORT_SWAP_CNT_EN
  ,
  output logic [$clog2(LP*(LP+1)/2*(2**(LP-1))):0] swap_cnt
`endif
);

  localparam int PN = 2 ** LP;
  localparam int KW = $clog2(LP + 1);
  localparam logic [LP-1:0] ONE_J = 1;
  localparam logic [LP:0]   ONE_K = 1;
  localparam logic [KW-1:0] K_MAX = KW'(LP);
  localparam logic          DIR_B = (dir != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_accept;
  logic                     w_last;
  logic [KW-1:0]            r_k;
  logic [KW-1:0]            r_j;
  logic [PN-1:0][dw-1:0]    r_data;
  logic [PN-1:0][dw-1:0]    r_dout;
  logic [PN-1:0][dw-1:0]    w_next;
  logic [LP-1:0]            w_bit;

  // Partner distance of the current stage.
  assign w_bit  = ONE_J << r_j;
  assign w_last = (r_j == '0) && (r_k == K_MAX);

  // Each element picks its new value from itself or its partner. Both members of a
  // pair evaluate the same decision from the lower index, so they stay consistent.
  genvar gi;
  generate
    for (gi = 0; gi < PN; gi++) begin : g_cx
      localparam logic [LP-1:0] IDX = gi;
      logic [LP-1:0] w_p;
      logic [LP-1:0] w_lo;
      logic [LP-1:0] w_hi;
      logic          w_up;
      logic          w_swap;

      assign w_p  = IDX ^ w_bit;
      assign w_lo = IDX & ~w_bit;
      assign w_hi = IDX | w_bit;
      // Bit k of the lower index picks the block direction; at k=LP the mask lands
      // above the index range, so the whole array sorts up.
      assign w_up   = ~|({1'b0, w_lo} & (ONE_K << r_k)) ^ DIR_B;
      assign w_swap = w_up ? (r_data[w_lo] > r_data[w_hi])
                           : (r_data[w_lo] < r_data[w_hi]);
      assign w_next[gi] = w_swap ? r_data[w_p] : r_data[gi];
    end
  endgenerate

`ifdef BSORT_SWAP_CNT_EN
  localparam int CW = $clog2(LP*(LP+1)/2*(2**(LP-1))) + 1;
  logic [PN-1:0] w_pair_swap;
  logic [CW-1:0] w_nswap;
  logic [CW-1:0] r_swap_cnt;

  // Count each swapped pair once, from its lower member.
  generate
    for (gi = 0; gi < PN; gi++) begin : g_cnt
      assign w_pair_swap[gi] = ~|(LP'(gi) & w_bit) & g_cx[gi].w_swap;
    end
  endgenerate

  always_comb begin
    w_nswap = '0;
    for (int i = 0; i < PN; i++) begin
      w_nswap = w_nswap + CW'(w_pair_swap[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_swap_cnt <= '0;
    end else if (!clr) begin
      if (w_accept) begin
        r_swap_cnt <= '0;
      end else if (r_state == S_SORT) begin
        r_swap_cnt <= r_swap_cnt + w_nswap;
      end
    end
  end

  assign swap_cnt = r_swap_cnt;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; clr overrides every transition, including an accept.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (clr) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_state_nxt = S_SORT;
            w_accept    = 1'b1;
          end
        end
        S_SORT: begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Data array, stage counters and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_dout <= '0;
      r_k    <= '0;
      r_j    <= '0;
    end else if (!clr) begin
      if (w_accept) begin
        r_data <= d_in;
        r_k    <= KW'(1);
        r_j    <= '0;
      end else if (r_state == S_SORT) begin
        r_data <= w_next;
        if (r_j != '0) begin
          r_j <= r_j - 1'b1;
        end else if (r_k != K_MAX) begin
          // New merge width: j restarts at (new k) - 1, which is the old k.
          r_k <= r_k + 1'b1;
          r_j <= r_k;
        end
        if (w_last) begin
          r_dout <= w_next;
        end
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_SORT);
  assign out_valid = (r_state == S_DONE);
  assign d_out     = r_dout;

endmodule
